// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm unit.
//   state_e        - alarm FSM states
//   HOUR_MAX/MIN_MAX - BCD wrap limits for the editable alarm fields
//   RST_AL_H/M     - alarm time after reset (07:00)
//   TICKS_PER_*    - tick_1kHz counts for seconds/minutes, blink half period
//   bcd2_inc       - two-digit BCD increment with wrap to 00 at a limit
package alarm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_ARMED,
    S_RINGING,
    S_SNOOZE
  } state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] RST_AL_H = 8'h07;
  localparam logic [7:0] RST_AL_M = 8'h00;

  localparam int TICKS_PER_SEC = 1000;
  localparam int TICKS_PER_MIN = 60000;
  localparam int BLINK_HALF    = 250;
  localparam int CNT_W         = 20;

  // bit positions of the buttons in the edge-detector array
  localparam int BTN_SET    = 0;
  localparam int BTN_INC_H  = 1;
  localparam int BTN_INC_M  = 2;
  localparam int BTN_SNOOZE = 3;
  localparam int NUM_BTN    = 4;

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: front-panel/time inputs and alarm outputs of alarm_ctrl.
//   inputs : tick_1kHz, h1/h0/m1/m0/s1/s0 (live BCD time), btn_set, btn_inc_h,
//            btn_inc_m, btn_snooze, swt_arm
//   outputs: al_h1/al_h0/al_m1/al_m0 (alarm BCD), editing, armed, ringing,
//            snoozed, blink
// master = the side driving time and buttons; slave = alarm_ctrl.
interface alarm_ctrl_if;
  logic       tick_1kHz;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic       btn_set, btn_inc_h, btn_inc_m, btn_snooze;
  logic       swt_arm;
  logic [3:0] al_h1, al_h0, al_m1, al_m0;
  logic       editing, armed, ringing, snoozed;
  logic       blink;

  modport master (
    output tick_1kHz, h1, h0, m1, m0, s1, s0,
    output btn_set, btn_inc_h, btn_inc_m, btn_snooze, swt_arm,
    input  al_h1, al_h0, al_m1, al_m0, editing, armed, ringing, snoozed, blink
  );

  modport slave (
    input  tick_1kHz, h1, h0, m1, m0, s1, s0,
    input  btn_set, btn_inc_h, btn_inc_m, btn_snooze, swt_arm,
    output al_h1, al_h0, al_m1, al_m0, editing, armed, ringing, snoozed, blink
  );
endinterface

// File: rtl/alarm_ctrl_rise_detect.sv
// rise_detect: registered rising-edge detector for a debounced button level.
//   clk_i, rst_i (async, active-high), lvl_i (button level),
//   rise_o (one-cycle pulse, decoded from the two registers only)
// The first register samples the level, the second holds last cycle's sample;
// the pulse therefore appears one cycle after the level rises.
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic rise_o
);
  logic sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= lvl_i;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time store, edit, ring/snooze/timeout controller.
//   CLK, RST (async, active-high)
//   al_if (slave): live BCD time, tick_1kHz, buttons, swt_arm in;
//                  alarm BCD digits, state flags, blink out
// Parameters: RING_SEC (2..255), SNOOZE_MIN (1..15); out-of-range values
// are clamped when the counter load constants are formed.
// Optional macro ALARM_BLINK_EN: blink toggles every BLINK_HALF ticks while
// ringing; otherwise blink simply mirrors ringing.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic CLK,
  input  logic RST,
  alarm_ctrl_if.slave al_if
);

  localparam int RING_SEC_C   = (RING_SEC < 2) ? 2 : (RING_SEC > 255) ? 255 : RING_SEC;
  localparam int SNOOZE_MIN_C = (SNOOZE_MIN < 1) ? 1 : (SNOOZE_MIN > 15) ? 15 : SNOOZE_MIN;
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC_C * TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN_C * TICKS_PER_MIN);

  // button edges
  logic [NUM_BTN-1:0] btn_lvl, btn_rise;
  assign btn_lvl[BTN_SET]    = al_if.btn_set;
  assign btn_lvl[BTN_INC_H]  = al_if.btn_inc_h;
  assign btn_lvl[BTN_INC_M]  = al_if.btn_inc_m;
  assign btn_lvl[BTN_SNOOZE] = al_if.btn_snooze;

  rise_detect u_rd [NUM_BTN-1:0] (
    .clk_i  (CLK),
    .rst_i  (RST),
    .lvl_i  (btn_lvl),
    .rise_o (btn_rise)
  );

  logic set_rise, inc_h_rise, inc_m_rise, snz_rise;
  assign set_rise   = btn_rise[BTN_SET];
  assign inc_h_rise = btn_rise[BTN_INC_H];
  assign inc_m_rise = btn_rise[BTN_INC_M];
  assign snz_rise   = btn_rise[BTN_SNOOZE];

  logic tick, arm;
  assign tick = al_if.tick_1kHz;
  assign arm  = al_if.swt_arm;

  state_e           state_q;
  logic [7:0]       al_h_q, al_m_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      hm_q;
  logic [7:0]       sec_q;
  logic             match_prev_q;

  // compare registered time against the alarm only at second 00
  logic match, match_rise, expire;
  assign match      = (hm_q == {al_h_q, al_m_q}) && (sec_q == 8'h00);
  assign match_rise = match & ~match_prev_q;
  // the tick that takes the counter to zero ends the phase in the same cycle
  assign expire     = tick && (cnt_q <= CNT_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      al_h_q       <= RST_AL_H;
      al_m_q       <= RST_AL_M;
      cnt_q        <= '0;
      hm_q         <= '0;
      sec_q        <= '0;
      match_prev_q <= 1'b0;
    end else begin
      hm_q         <= {al_if.h1, al_if.h0, al_if.m1, al_if.m0};
      sec_q        <= {al_if.s1, al_if.s0};
      // tracked in every state so arming during a matching second is silent
      match_prev_q <= match;
      unique case (state_q)
        S_IDLE: begin
          if (set_rise)  state_q <= S_SET;
          else if (arm)  state_q <= S_ARMED;
        end
        S_SET: begin
          // both fields may step in the same cycle; no minute->hour carry
          if (inc_h_rise) al_h_q <= bcd2_inc(al_h_q, HOUR_MAX);
          if (inc_m_rise) al_m_q <= bcd2_inc(al_m_q, MIN_MAX);
          if (set_rise)   state_q <= arm ? S_ARMED : S_IDLE;
        end
        S_ARMED: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (match_rise) begin
            state_q <= S_RINGING;
            cnt_q   <= RING_LOAD;
          end else if (set_rise) begin
            state_q <= S_SET;
          end
        end
        S_RINGING: begin
          if (!arm) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (expire) begin
            state_q <= S_ARMED;
            cnt_q   <= '0;
          end else if (snz_rise) begin
            state_q <= S_SNOOZE;
            cnt_q   <= SNOOZE_LOAD;
          end else if (tick) begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        S_SNOOZE: begin
          if (!arm) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (expire) begin
            state_q <= S_RINGING;
            cnt_q   <= RING_LOAD;
          end else if (tick) begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic ringing;
  assign ringing = (state_q == S_RINGING);

  assign al_if.editing = (state_q == S_SET);
  assign al_if.armed   = (state_q == S_ARMED);
  assign al_if.ringing = ringing;
  assign al_if.snoozed = (state_q == S_SNOOZE);
  assign {al_if.al_h1, al_if.al_h0} = al_h_q;
  assign {al_if.al_m1, al_if.al_m0} = al_m_q;

`ifdef ALARM_BLINK_EN
  // Outside RINGING the phase is pre-set to 1 so the first ringing cycle
  // already shows 1; the output is gated by ringing so it reads 0 elsewhere.
  // The entry cycle is spent outside RINGING, so its tick is not counted.
  logic [7:0] bdiv_q;
  logic       blink_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bdiv_q  <= '0;
      blink_q <= 1'b0;
    end else if (!ringing) begin
      bdiv_q  <= '0;
      blink_q <= 1'b1;
    end else if (tick) begin
      if (bdiv_q == 8'(BLINK_HALF - 1)) begin
        bdiv_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bdiv_q  <= bdiv_q + 8'd1;
      end
    end
  end

  assign al_if.blink = blink_q & ringing;
`else
  assign al_if.blink = ringing;
`endif

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm unit downstream of the 24-hour clock counter, alongside the mode multiplexer feeding `bcd_to_number`/`screen`. It takes the running BCD time digits and the debounced front-panel buttons. It holds a user-set alarm time in BCD, raises `ringing` when the time reaches HH:MM:00, and handles snooze, timeout and disarm. Its alarm digits are offered to the display mux as a fifth source.

## Interface
Parameters:
- `RING_SEC`, 60: ringing auto-timeout in seconds; legal range 2–255.
- `SNOOZE_MIN`, 5: snooze length in minutes; legal range 1–15.

Ports:
- `CLK` in 1: system clock, 100 MHz.
- `RST` in 1: reset, asynchronous, active-high.
- `tick_1kHz` in 1: one-`CLK`-wide strobe, once per ms.
- `h1, h0, m1, m0, s1, s0` in 4 each: live 24-hour BCD time.
- `btn_set` in 1: debounced level; toggles edit of the alarm time.
- `btn_inc_h`, `btn_inc_m` in 1: debounced levels; increment alarm hour / minute.
- `btn_snooze` in 1: debounced level.
- `swt_arm` in 1: level; 1 = alarm enabled.
- `al_h1, al_h0, al_m1, al_m0` out 4 each: alarm time, BCD.
- `editing`, `armed`, `ringing`, `snoozed` out 1: state flags.
- `blink` out 1: ring indicator (see Configuration).

## Operation
- Every button goes through a rising-edge detector. Only the edge acts; holding a button has no further effect.
- States: IDLE, SET, ARMED, RINGING, SNOOZE.
  - IDLE: if `swt_arm`=1, go to ARMED. A `btn_set` edge goes to SET.
  - SET: a `btn_inc_h` edge increments the hour, 00..23 with wrap 23→00. A `btn_inc_m` edge increments the minute, 00..59 with wrap 59→00 and no carry into the hour. A `btn_set` edge exits to ARMED if `swt_arm`=1, else to IDLE. `swt_arm` changes do not exit SET.
  - ARMED: a `btn_set` edge goes to SET. `swt_arm`=0 goes to IDLE. A rising edge of `match` goes to RINGING and loads counter = RING_SEC×1000.
  - RINGING: counter decrements on each `tick_1kHz`. At 0, go to ARMED. A `btn_snooze` edge goes to SNOOZE and loads counter = SNOOZE_MIN×60000. `btn_set` is ignored.
  - SNOOZE: counter decrements on each tick. At 0, go to RINGING and reload RING_SEC×1000. `btn_set` and `btn_snooze` are ignored.
- `match` = (h1,h0,m1,m0 == alarm digits) AND s1==0 AND s0==0, computed from registered inputs.
- `match_prev` updates every cycle in every state. Arming in the middle of a matching second therefore does not ring.
- Priority, highest first: `RST`, then `swt_arm`=0 (forces IDLE from ARMED/RINGING/SNOOZE), then counter expiry, then button edges.
- If increment edges for hour and minute arrive in the same cycle, both fields are applied.
- Counter is 20 bits unsigned; loads saturate to the parameter ranges.

## Timing
- Reset values: state IDLE; alarm digits 0,7,0,0 (07:00); all flags 0; counter 0; `blink` 0; edge-detect registers 0.
- Input button edge → state/digit change: 2 `CLK` cycles (sync register + edge register).
- Time digits change → `ringing`=1: 2 cycles (input register + match-edge/state register).
- All outputs are registered; flags decode the current state with no extra latency.
- Ring timeout: `ringing` falls exactly RING_SEC×1000 ticks after entry.
- A `tick_1kHz` in the entry cycle is not counted.

## Configuration
- `ALARM_BLINK_EN` defined: `blink` toggles every 250 ticks while RINGING, starting at 1 on entry, and is 0 in every other state.
- `ALARM_BLINK_EN` undefined: `blink` = `ringing`, and the blink divider is not synthesised.

## Structure
- `alarm_pkg` holds:
  - state typedef (IDLE/SET/ARMED/RINGING/SNOOZE);
  - BCD limits (HOUR_MAX=23, MIN_MAX=59);
  - reset alarm digits;
  - TICKS_PER_SEC=1000, TICKS_PER_MIN=60000, BLINK_HALF=250.
- One sub-module `rise_detect`: registered rising-edge detector, instantiated for `btn_set`, `btn_inc_h`, `btn_inc_m` and `btn_snooze`.

## Test plan
- Reset, press set, press inc_h ×17, press inc_m ×61, press set with `swt_arm`=1: alarm = 00:01 (07+17 = 24 wraps to 00; 61 minute presses wrap to 01), state ARMED.
- Alarm 07:00, armed, drive time 06:59:59 → 07:00:00: `ringing`=1 two cycles later. Hold 07:00:00 for 5000 cycles: exactly one entry into RINGING.
- In RINGING, press snooze: `snoozed`=1. After 300000 ticks (SNOOZE_MIN=5), `ringing`=1 again.
- In RINGING, issue no input for 60000 ticks: return to ARMED. Set `swt_arm`=0 mid-SNOOZE: IDLE next state cycle.
- Set `swt_arm`=1 while time already reads 07:00:00: no ring. Assert `RST` mid-RINGING: all flags 0 and alarm back to 07:00 immediately, with no clock edge needed.
- With `ALARM_BLINK_EN`: `blink` period is 500 ticks during RINGING. Without it: `blink` == `ringing` every cycle.
